// File: rtl/rt_pkg.sv
// Shared defaults, coordinate types and FSM encoding for the ray-trace pixel sequencer.
package rt_pkg;

  localparam int H_RES_DEF   = 640;
  localparam int V_RES_DEF   = 480;
  localparam int PIXEL_W_DEF = 4;
  localparam int X_W         = 10;
  localparam int Y_W         = 9;

  localparam logic [PIXEL_W_DEF-1:0] ERR_PIXEL_DEF = 4'hF;

  typedef logic [X_W-1:0] x_t;
  typedef logic [Y_W-1:0] y_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rt_raster_counter.sv
// Raster X/Y position and linear framebuffer address; clear has priority over advance.
// Address is kept incrementally alongside X/Y so no Y*H_RES multiply is needed.
module rt_raster_counter
  import rt_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = 19
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              adv_i,
  output x_t                x_o,
  output y_t                y_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  x_t                x_q, x_d;
  y_t                y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              x_end;

  assign x_end  = (x_q == x_t'(H_RES - 1));
  assign last_o = x_end && (y_q == y_t'(V_RES - 1));

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clr_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (adv_i) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/rt_pixel_sequencer.sv
// Raster-order frame scan: issue pixel to the ray-trace core, await result (with watchdog),
// push it to the framebuffer; >=4 cycles/pixel, holds the write until FB_READY.
module rt_pixel_sequencer
  import rt_pkg::*;
#(
  parameter int                 H_RES     = H_RES_DEF,
  parameter int                 V_RES     = V_RES_DEF,
  parameter int                 PIXEL_W   = PIXEL_W_DEF,
  parameter int                 ADDR_W    = 19,
  parameter int                 TIMEOUT   = 65535,
  parameter logic [PIXEL_W-1:0] ERR_PIXEL = PIXEL_W'(ERR_PIXEL_DEF)
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               FRAME_START,
  output logic               BUSY,
  output logic               FRAME_DONE,
  output logic               TIMEOUT_ERR,
  output logic               RT_ENABLE,
  output x_t                 RT_X,
  output y_t                 RT_Y,
  input  logic               RT_READY,
  input  logic [PIXEL_W-1:0] RT_PIXEL,
  output logic               FB_WE,
  output logic [ADDR_W-1:0]  FB_ADDR,
  output logic [PIXEL_W-1:0] FB_DATA,
  input  logic               FB_READY
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [PIXEL_W-1:0] data_q, data_d;
  logic               terr_q, terr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               en_q, en_d;
  logic               we_q, we_d;
  logic               cnt_clr, cnt_adv, cnt_last;
  logic               wd_fire;

  rt_raster_counter #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .clr_i  (cnt_clr),
    .adv_i  (cnt_adv),
    .x_o    (RT_X),
    .y_o    (RT_Y),
    .addr_o (FB_ADDR),
    .last_o (cnt_last)
  );

  // wd_q is 0 in the first WAIT cycle, so this is the TIMEOUT-th WAIT cycle.
  assign wd_fire = (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    data_d  = data_q;
    terr_d  = terr_q;
    cnt_clr = 1'b0;
    cnt_adv = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (FRAME_START) begin
          cnt_clr = 1'b1;
          terr_d  = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_GUARD;
      ST_GUARD: begin
        // The core may still show READY from the previous pixel here.
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (RT_READY) begin
          data_d  = RT_PIXEL;
          state_d = ST_WRITE;
        end else if (wd_fire) begin
          data_d  = ERR_PIXEL;
          terr_d  = 1'b1;
          state_d = ST_WRITE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_WRITE: begin
        if (FB_READY) begin
          if (cnt_last) begin
            state_d = ST_DONE;
          end else begin
            cnt_adv = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        cnt_clr = 1'b1;
        wd_d    = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    en_d   = (state_d == ST_ISSUE);
    we_d   = (state_d == ST_WRITE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
      data_q  <= '0;
      terr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      data_q  <= data_d;
      terr_q  <= terr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      we_q    <= we_d;
    end
  end

  assign BUSY        = busy_q;
  assign FRAME_DONE  = done_q;
  assign TIMEOUT_ERR = terr_q;
  assign RT_ENABLE   = en_q;
  assign FB_WE       = we_q;
  assign FB_DATA     = data_q;

endmodule

// File: tb/tb_rt_pixel_sequencer.sv
// Directed bench for rt_pixel_sequencer on a 4x3 frame with a behavioural core and framebuffer.
module tb_rt_pixel_sequencer;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int PW = 4;
  localparam int AW = 4;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          FRAME_START;
  logic          BUSY, FRAME_DONE, TIMEOUT_ERR, RT_ENABLE, FB_WE;
  logic [9:0]    RT_X;
  logic [8:0]    RT_Y;
  logic          RT_READY;
  logic [PW-1:0] RT_PIXEL;
  logic [AW-1:0] FB_ADDR;
  logic [PW-1:0] FB_DATA;
  logic          FB_READY;

  rt_pixel_sequencer #(
    .H_RES(H), .V_RES(V), .PIXEL_W(PW), .ADDR_W(AW), .TIMEOUT(TO), .ERR_PIXEL(4'hF)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FRAME_START(FRAME_START),
    .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .TIMEOUT_ERR(TIMEOUT_ERR),
    .RT_ENABLE(RT_ENABLE), .RT_X(RT_X), .RT_Y(RT_Y),
    .RT_READY(RT_READY), .RT_PIXEL(RT_PIXEL),
    .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .FB_READY(FB_READY)
  );

  always #5 CLK = ~CLK;

  // Knobs written only by the stimulus block.
  int core_mode = 0;   // 0: READY 3 cycles after ENABLE, 1: stale READY held across ENABLE
  int seed      = 1;
  bit noans_en  = 1'b0;
  int bp_stall  = 0;
  int clr_req   = 0;
  int errors    = 0;
  int checks    = 0;
  int start_cyc = 0;

  // Written only by the model/monitor block.
  int            cyc, age, wcnt, clr_seen;
  int            wr_cnt, en_cnt, done_cnt, done_cyc, last_acc_cyc;
  int            bp_bad, en_bad, gap_bad;
  logic [AW-1:0] wr_addr [0:31];
  logic [PW-1:0] wr_data [0:31];
  logic [9:0]    en_x    [0:31];
  logic [8:0]    en_y    [0:31];
  logic [AW-1:0] en_addr [0:31];
  logic          prev_we, prev_acc, prev_en;
  logic [AW-1:0] prev_addr;
  logic [PW-1:0] prev_data;

  function automatic logic [3:0] pix(input int x, input int y, input int s);
    return 4'((x * 3 + y * 7 + s) & 15);
  endfunction

  initial begin
    RT_READY = 1'b0; RT_PIXEL = '0; FB_READY = 1'b0;
    cyc = 0; age = 100; wcnt = 0; clr_seen = 0;
    wr_cnt = 0; en_cnt = 0; done_cnt = 0; done_cyc = 0; last_acc_cyc = -10;
    bp_bad = 0; en_bad = 0; gap_bad = 0;
    prev_we = 1'b0; prev_acc = 1'b0; prev_en = 1'b0; prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (clr_req != clr_seen) begin
        clr_seen = clr_req;
        wr_cnt = 0; en_cnt = 0; done_cnt = 0; done_cyc = 0; last_acc_cyc = -10;
        bp_bad = 0; en_bad = 0; gap_bad = 0;
      end
      // Ray-trace core model; stale window returns corrupted data.
      if (RT_ENABLE) age = 0;
      else if (age < 100) age++;
      if (core_mode == 1) begin
        RT_READY = !(age == 2 || age == 3);
        RT_PIXEL = pix(int'(RT_X), int'(RT_Y), seed) ^ ((age < 2) ? 4'hA : 4'h0);
      end else begin
        RT_READY = (age >= 3);
        RT_PIXEL = RT_READY ? pix(int'(RT_X), int'(RT_Y), seed) : 4'h5;
      end
      if (noans_en && RT_X == 10'd2 && RT_Y == 9'd1) RT_READY = 1'b0;
      // Framebuffer model: accept after bp_stall cycles of FB_WE.
      if (FB_WE) wcnt++;
      else wcnt = 0;
      FB_READY = (wcnt > bp_stall);
      // Monitor.
      if (prev_we && !prev_acc &&
          !(FB_WE === 1'b1 && FB_ADDR === prev_addr && FB_DATA === prev_data)) bp_bad++;
      if (RT_ENABLE && (FB_WE || prev_en)) en_bad++;
      if (RT_ENABLE) begin
        if (en_cnt > 0 && last_acc_cyc != cyc - 1) gap_bad++;
        if (en_cnt < 32) begin
          en_x[en_cnt] = RT_X; en_y[en_cnt] = RT_Y; en_addr[en_cnt] = FB_ADDR;
        end
        en_cnt++;
      end
      if (FB_WE && FB_READY) begin
        if (wr_cnt < 32) begin
          wr_addr[wr_cnt] = FB_ADDR; wr_data[wr_cnt] = FB_DATA;
        end
        wr_cnt++;
        last_acc_cyc = cyc;
      end
      if (FRAME_DONE) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_we = FB_WE; prev_acc = FB_WE && FB_READY; prev_en = RT_ENABLE;
      prev_addr = FB_ADDR; prev_data = FB_DATA;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    clr_req++;
    step();
  endtask

  task automatic start_frame();
    FRAME_START = 1'b1;
    start_cyc   = cyc;
    step();
    FRAME_START = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (FRAME_DONE !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("frame_done_seen", 32'(FRAME_DONE), 1);
  endtask

  task automatic check_frame(input int s, input bit wd_pixel);
    logic [3:0] e;
    chk("wr_count", wr_cnt, 12);
    chk("enable_count", en_cnt, 12);
    chk("done_count", done_cnt, 1);
    chk("bp_unstable", bp_bad, 0);
    chk("enable_overlap", en_bad, 0);
    chk("enable_gap", gap_bad, 0);
    for (int i = 0; i < 12; i++) begin
      e = (wd_pixel && i == 6) ? 4'hF : pix(i % H, i / H, s);
      chk($sformatf("wr_addr[%0d]", i), 32'(wr_addr[i]), i);
      chk($sformatf("wr_data[%0d]", i), 32'(wr_data[i]), 32'(e));
    end
  endtask

  initial begin
    RESET_N = 1'b0; FRAME_START = 1'b0;
    repeat (3) step();
    chk("reset_outputs", {BUSY, FRAME_DONE, TIMEOUT_ERR, RT_ENABLE, RT_X, RT_Y,
                          FB_WE, FB_ADDR, FB_DATA}, 0);
    RESET_N = 1'b1;
    step(); step();
    chk("idle_busy", 32'(BUSY), 0);

    // Frame 1: nominal core, no backpressure.
    core_mode = 0; seed = 1;
    clr_mon();
    start_frame();
    chk("f1_enable_n1", 32'(RT_ENABLE), 1);
    chk("f1_busy_n1", 32'(BUSY), 1);
    chk("f1_xy_n1", {RT_X, RT_Y}, 0);
    chk("f1_addr_n1", 32'(FB_ADDR), 0);
    wait_done(400);
    chk("f1_done_latency", done_cyc - start_cyc, 61);
    chk("f1_busy_at_done", 32'(BUSY), 1);
    chk("f1_terr", 32'(TIMEOUT_ERR), 0);
    step();
    chk("f1_done_pulse", 32'(FRAME_DONE), 0);
    chk("f1_busy_after", 32'(BUSY), 0);
    check_frame(1, 1'b0);
    chk("wrap_pre_x", 32'(en_x[3]), 3);
    chk("wrap_pre_y", 32'(en_y[3]), 0);
    chk("wrap_x", 32'(en_x[4]), 0);
    chk("wrap_y", 32'(en_y[4]), 1);
    chk("wrap_addr", 32'(en_addr[4]), 4);

    // Frame 2: stale READY across ENABLE, plus an ignored mid-frame FRAME_START.
    core_mode = 1; seed = 5;
    clr_mon();
    start_frame();
    repeat (20) step();
    FRAME_START = 1'b1;
    step();
    FRAME_START = 1'b0;
    wait_done(400);
    chk("f2_done_latency", done_cyc - start_cyc, 73);
    step();
    check_frame(5, 1'b0);
    core_mode = 0;

    // Frame 3: framebuffer stalls 5 cycles per write.
    bp_stall = 5; seed = 9;
    clr_mon();
    start_frame();
    wait_done(600);
    chk("f3_done_latency", done_cyc - start_cyc, 121);
    step();
    check_frame(9, 1'b0);
    bp_stall = 0;

    // Frame 4: core never answers pixel (2,1).
    noans_en = 1'b1; seed = 3;
    clr_mon();
    start_frame();
    wait_done(400);
    chk("f4_done_latency", done_cyc - start_cyc, 67);
    chk("f4_terr_at_done", 32'(TIMEOUT_ERR), 1);
    step(); step();
    chk("f4_terr_sticky", 32'(TIMEOUT_ERR), 1);
    check_frame(3, 1'b1);
    noans_en = 1'b0;

    // Frame 5: flag cleared on start, then reset while pixel 5 is issued.
    seed = 7;
    clr_mon();
    start_frame();
    chk("f5_terr_cleared", 32'(TIMEOUT_ERR), 0);
    for (int n = 0; n < 200 && wr_cnt < 5; n++) step();
    chk("f5_reached_pixel5", wr_cnt, 5);
    step();
    chk("f5_enable_pixel5", {RT_ENABLE, 28'(FB_ADDR)}, {1'b1, 28'd5});
    RESET_N = 1'b0;
    #1;
    chk("f5_async_reset", {BUSY, FRAME_DONE, TIMEOUT_ERR, RT_ENABLE, RT_X, RT_Y,
                           FB_WE, FB_ADDR, FB_DATA}, 0);
    repeat (3) step();
    chk("f5_no_done", done_cnt, 0);
    chk("f5_no_more_writes", wr_cnt, 5);
    RESET_N = 1'b1;
    step();

    // Frame 6: restart after abort begins at address 0.
    seed = 11;
    clr_mon();
    start_frame();
    chk("f6_addr_restart", {RT_ENABLE, 28'(FB_ADDR)}, {1'b1, 28'd0});
    wait_done(400);
    chk("f6_done_latency", done_cyc - start_cyc, 61);
    step();
    check_frame(11, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rt_pixel_sequencer.md
# rt_pixel_sequencer

Frame-scan controller sitting directly upstream of the ray-trace core. On a frame request it walks every pixel in raster order, presents X/Y to the core, pulses the core's enable, waits for the core's ready, captures the returned pixel and pushes it to the framebuffer write port with a valid/ready handshake. It replaces bench-side scan logic in the synthesized design and signals frame completion to the display/control side.

## Interface
Parameters:
- H_RES, 640, pixels per line (X range 0..H_RES-1)
- V_RES, 480, lines per frame (Y range 0..V_RES-1)
- PIXEL_W, 4, pixel data width
- ADDR_W, 19, framebuffer address width (must satisfy 2^ADDR_W >= H_RES*V_RES)
- TIMEOUT, 65535, max WAIT cycles per pixel before the watchdog fires
- ERR_PIXEL, 4'hF, value written when the watchdog fires

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous active-low reset
- FRAME_START  in  1  single-cycle frame request
- BUSY  out  1  high from accepted FRAME_START until FRAME_DONE inclusive
- FRAME_DONE  out  1  single-cycle pulse after last pixel accepted by framebuffer
- TIMEOUT_ERR  out  1  sticky; set when any pixel timed out, cleared by next accepted FRAME_START
- RT_ENABLE  out  1  single-cycle start pulse to ray-trace core
- RT_X  out  10  pixel column, stable from ISSUE through WRITE
- RT_Y  out  9  pixel row, stable from ISSUE through WRITE
- RT_READY  in  1  core result-valid level
- RT_PIXEL  in  PIXEL_W  core result, valid while RT_READY high
- FB_WE  out  1  framebuffer write valid
- FB_ADDR  out  ADDR_W  Y*H_RES + X
- FB_DATA  out  PIXEL_W  captured pixel
- FB_READY  in  1  framebuffer accepts write when FB_WE && FB_READY

## Operation
- All outputs registered. Reset value of every output: 0. Reset puts FSM in IDLE, counters X=Y=ADDR=0, watchdog=0.
- States: IDLE, ISSUE, GUARD, WAIT, WRITE, DONE.
- IDLE: FRAME_START -> clear X/Y/ADDR/TIMEOUT_ERR, BUSY=1, go ISSUE.
- ISSUE: RT_ENABLE=1 for exactly this cycle -> GUARD.
- GUARD: one cycle, RT_READY ignored (core drops stale READY within one cycle of ENABLE) -> WAIT.
- WAIT: watchdog counts up. RT_READY=1 -> latch RT_PIXEL into FB_DATA, FB_WE=1, go WRITE. Watchdog reaching TIMEOUT -> FB_DATA=ERR_PIXEL, TIMEOUT_ERR=1, FB_WE=1, go WRITE. RT_READY wins if both in same cycle.
- WRITE: hold FB_WE/FB_ADDR/FB_DATA until FB_READY. On acceptance: FB_WE=0; if X==H_RES-1 and Y==V_RES-1 go DONE; else advance and go ISSUE.
- Advance: X==H_RES-1 -> X=0, Y=Y+1; else X=X+1. ADDR=ADDR+1 always (incremental, no multiplier). Wrap-around only at frame end.
- DONE: FRAME_DONE=1 one cycle, BUSY=0 next cycle, counters reset to 0, go IDLE.
- FRAME_START outside IDLE ignored (no queuing).
- Reset mid-frame: immediate abort, outputs 0, no FRAME_DONE.

## Timing
- FRAME_START at cycle n -> RT_ENABLE high at n+1, X=Y=0 visible at n+1.
- Per pixel: ISSUE 1 + GUARD 1 + WAIT k (k>=1) + WRITE m (m>=1 cycles until FB_READY). Minimum 4 cycles/pixel.
- RT_READY sampled in WAIT cycle c -> FB_WE high at c+1.
- FB_READY high in first WRITE cycle -> next RT_ENABLE the following cycle.
- Last acceptance at cycle c -> FRAME_DONE at c+1, BUSY low at c+2.
- Watchdog: fires on the TIMEOUT-th WAIT cycle without RT_READY.

## Structure
- Shared package rt_pkg: H_RES/V_RES/PIXEL_W defaults, X/Y typedefs (10/9 bits), FSM state enum, ERR_PIXEL constant.
- Sub-module rt_raster_counter: X/Y/ADDR counters with clear, advance and last-pixel flag; FSM stays in the top.

## Test plan
- H_RES=4,V_RES=3, core model READY 3 cycles after ENABLE, FB_READY=1 -> 12 writes, ADDR 0..11 in order, FB_DATA equals model pixel, single FRAME_DONE, TIMEOUT_ERR=0.
- Stale READY: model holds RT_READY=1 continuously, drops it the cycle after ENABLE, re-raises after 2 cycles -> exactly one write per pixel, no skipped ENABLE.
- Backpressure: FB_READY low 5 cycles per write -> FB_WE/ADDR/DATA stable throughout, no ENABLE until acceptance.
- Watchdog: TIMEOUT=8, core never answers pixel (2,1) -> ADDR 6 written with 4'hF, TIMEOUT_ERR=1, frame completes; next FRAME_START clears flag.
- FRAME_START pulsed mid-frame -> ignored, sequence unchanged; RESET_N low at pixel 5 -> all outputs 0 asynchronously, no FRAME_DONE, next frame restarts at ADDR 0.
- Line wrap: X=3,Y=0 accepted -> X=0,Y=1,ADDR=4 next ISSUE.
